// File: rtl/count_pkg.sv
// Shared constants for the modulo counter family: direction encoding and width limit.
package count_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam int   MAX_WIDTH = 16;

endpackage

// File: rtl/count_mod_load.sv
// Modulo-N up/down counter with parallel load, cascadable through tc -> en.
// Optional macro COUNT_MOD_SAT_EN: saturate at the range ends instead of wrapping.
module count_mod_load
    import count_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    generate
        if (WIDTH < 1 || WIDTH > MAX_WIDTH || MODULUS < 2 || MODULUS > (1 << WIDTH) ||
            RST_VAL < 0 || RST_VAL >= MODULUS) begin : g_bad_param
            $error("count_mod_load: WIDTH/MODULUS/RST_VAL out of range");
        end
    endgenerate

    // MODULUS itself may be 2**WIDTH, so the range check needs one extra bit.
    localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] TOP   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);

    logic             dir_up;
    logic             in_range;
    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;
    logic             err_nxt;

    assign dir_up   = (up_down == DIR_UP);
    assign in_range = ({1'b0, data_in} < MOD_X);
    assign tc       = en & ~load & ((dir_up & (count == TOP)) | (~dir_up & (count == '0)));

    // tc is exactly "stepping past a range end"; inside the range +/-1 cannot overflow.
    always_comb begin
        count_nxt = count;
        wrap_nxt  = 1'b0;
        err_nxt   = 1'b0;
        if (load) begin
            if (in_range) begin
                count_nxt = data_in;
            end else begin
                count_nxt = TOP;
                err_nxt   = 1'b1;
            end
        end else if (en) begin
            if (tc) begin
`ifdef COUNT_MOD_SAT_EN
                count_nxt = count;
`else
                count_nxt = dir_up ? '0 : TOP;
                wrap_nxt  = 1'b1;
`endif
            end else begin
                count_nxt = dir_up ? count + WIDTH'(1) : count - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= RST_V;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            count    <= count_nxt;
            wrap     <= wrap_nxt;
            load_err <= err_nxt;
        end
    end

endmodule

// File: tb/tb_count_mod_load.sv
// Scoreboard bench for count_mod_load: single counter plus a two-digit BCD cascade.
module tb_count_mod_load;

`ifdef COUNT_MOD_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, en, up_down, load, ce;
    logic [3:0] data_in;
    logic [3:0] count, u_cnt, t_cnt;
    logic       tc, wrap, load_err;
    logic       u_tc, u_wrap, u_err, t_tc, t_wrap, t_err;

    always #5 clk = ~clk;

    count_mod_load #(.WIDTH(4), .MODULUS(10), .RST_VAL(0)) dut (
        .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load), .data_in(data_in),
        .count(count), .tc(tc), .wrap(wrap), .load_err(load_err)
    );

    count_mod_load #(.WIDTH(4), .MODULUS(10), .RST_VAL(0)) units (
        .clk(clk), .rst(rst), .en(ce), .up_down(1'b1), .load(1'b0), .data_in(4'd0),
        .count(u_cnt), .tc(u_tc), .wrap(u_wrap), .load_err(u_err)
    );

    count_mod_load #(.WIDTH(4), .MODULUS(10), .RST_VAL(0)) tens (
        .clk(clk), .rst(rst), .en(u_tc), .up_down(1'b1), .load(1'b0), .data_in(4'd0),
        .count(t_cnt), .tc(t_tc), .wrap(t_wrap), .load_err(t_err)
    );

    typedef struct {
        bit       chk_tc;
        bit       tc;
        int       cnt;
        bit       wrap;
        bit       err;
        bit       chk_cas;
        int       u;
        int       t;
    } exp_t;

    exp_t sb[$];
    int   tests  = 0;
    int   failed = 0;

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; the expected post-edge state is queued.
    task automatic step(input bit r, input bit e, input bit ud, input bit l, input int d,
                        input bit c_en, input bit ctc, input bit xtc, input int xcnt,
                        input bit xw, input bit xe, input bit ccas, input int xu, input int xt);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; up_down = ud; load = l; data_in = 4'(d); ce = c_en;
        x.chk_tc = ctc; x.tc = xtc; x.cnt = xcnt; x.wrap = xw; x.err = xe;
        x.chk_cas = ccas; x.u = xu; x.t = xt;
        sb.push_back(x);
    endtask

    initial begin : monitor
        exp_t e;
        logic tc_s;
        forever begin
            @(negedge clk);
            #1;
            if (sb.size() != 0) begin
                e    = sb.pop_front();
                tc_s = tc;
                @(posedge clk);
                #1;
                if (e.chk_tc) chk("tc", int'(tc_s), int'(e.tc));
                chk("count", int'(count), e.cnt);
                chk("wrap", int'(wrap), int'(e.wrap));
                chk("load_err", int'(load_err), int'(e.err));
                if (e.chk_cas) begin
                    chk("units", int'(u_cnt), e.u);
                    chk("tens", int'(t_cnt), e.t);
                end
            end
        end
    end

    initial begin : stim
        int pre, post;
        rst = 1'b1; en = 1'b0; up_down = 1'b1; load = 1'b0; data_in = 4'd0; ce = 1'b0;

        // reset overrides a pending load
        step(1, 1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        // reset mid-count abandons the step
        step(1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

        // up 15 cycles from 0
        for (int i = 0; i < 15; i++) begin
            pre  = SAT ? ((i > 9) ? 9 : i) : (i % 10);
            post = SAT ? ((i + 1 > 9) ? 9 : i + 1) : ((i + 1) % 10);
            step(0, 1, 1, 0, 0, 0, 1, (pre == 9), post, (!SAT && pre == 9), 0, 0, 0, 0);
        end

        // load 0 masks tc, no wrap on a boundary load
        step(0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        // down from 0
        step(0, 1, 0, 0, 0, 0, 1, 1, SAT ? 0 : 9, !SAT, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 1, SAT, SAT ? 0 : 8, 0, 0, 0, 0, 0);
        // direction flip takes effect immediately
        step(0, 1, 1, 0, 0, 0, 1, 0, SAT ? 1 : 9, 0, 0, 0, 0, 0);
        // hold
        step(0, 0, 1, 0, 0, 0, 1, 0, SAT ? 1 : 9, 0, 0, 0, 0, 0);
        // out-of-range load clamps to 9
        step(0, 1, 1, 1, 12, 0, 1, 0, 9, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 1, 0, 9, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 7, 0, 1, 0, 7, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 10, 0, 1, 0, 9, 0, 1, 0, 0, 0);
        step(0, 1, 1, 1, 9, 0, 1, 0, 9, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 1, 1, SAT ? 9 : 0, !SAT, 0, 0, 0, 0);
        // reset then resume on the first free edge
        step(1, 1, 1, 0, 0, 0, 1, SAT, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);

        // BCD cascade 00..99,00 while the single counter holds at 1
        for (int i = 0; i < 100; i++)
            step(0, 0, 1, 0, 0, 1, 1, 0, 1, 0, 0, !SAT, (i + 1) % 10, ((i + 1) / 10) % 10);

        step(0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, !SAT, 0, 0);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/count_mod_load.md
COUNT_MOD_LOAD -- requirements
Module: count_mod_load

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter and load-data width in bits (1..16).
REQ-002 SHALL have parameter MODULUS, default 10, count range 0..MODULUS-1 (2..2**WIDTH).
REQ-003 SHALL have parameter RST_VAL, default 0, value loaded by reset (0..MODULUS-1).
REQ-004 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port en  input  1  count enable; also the cascade carry-in.
REQ-007 SHALL have port up_down  input  1  1 = count up, 0 = count down.
REQ-008 SHALL have port load  input  1  parallel load request.
REQ-009 SHALL have port data_in  input  WIDTH  parallel load value.
REQ-010 SHALL have port count  output  WIDTH  registered count value.
REQ-011 SHALL have port tc  output  1  combinational terminal count.
REQ-012 SHALL have port wrap  output  1  registered one-cycle pulse after a wrap.
REQ-013 SHALL have port load_err  output  1  registered one-cycle pulse after an out-of-range load.

Function
REQ-014 SHALL update all registered outputs only on the rising edge of clk.
REQ-015 SHALL apply per-edge priority rst > load > en > hold.
REQ-016 SHALL, on load with data_in < MODULUS, set count = data_in and load_err = 0, regardless of en and up_down.
REQ-017 SHALL, on load with data_in >= MODULUS, set count = MODULUS-1 and pulse load_err for one cycle.
REQ-018 SHALL, on en = 1 with up_down = 1, set count = count+1, or 0 when count = MODULUS-1.
REQ-019 SHALL, on en = 1 with up_down = 0, set count = count-1, or MODULUS-1 when count = 0.
REQ-020 SHALL hold count when load = 0 and en = 0.
REQ-021 SHALL drive tc = en & ~load & ((up_down & count == MODULUS-1) | (~up_down & count == 0)), so tc of one stage feeds en of the next.
REQ-022 SHALL set wrap = 1 for exactly the cycle after an edge where tc was 1 and a wrap occurred; otherwise 0.
REQ-023 SHALL NOT pulse wrap on any load cycle, even when the loaded value equals a boundary.
REQ-024 SHALL apply a direction change on the same edge it is sampled, with no turnaround cycle.
REQ-025 SHALL do all arithmetic at WIDTH+1 bits internally so MODULUS = 2**WIDTH never overflows.

Reset
REQ-026 SHALL, on rst = 1 at a clk edge, set count = RST_VAL, wrap = 0 and load_err = 0, overriding load and en.
REQ-027 SHALL abandon any in-progress count step when rst is asserted mid-operation, and resume counting on the first edge after rst deasserts.

Configuration
REQ-028 SHALL support macro COUNT_MOD_SAT_EN.
- Defined: saturate instead of wrapping. Up at MODULUS-1 and down at 0 hold count, and wrap stays 0.
- Defined: tc keeps its REQ-021 definition.
- Undefined: wrap behaviour per REQ-018 and REQ-019.

Structure
REQ-029 SHALL place the direction constants DIR_UP = 1 and DIR_DOWN = 0, and the maximum-WIDTH constant 16, in shared package count_pkg.
REQ-030 SHALL be implemented as a single module with no sub-modules; a two-stage BCD clock-digit cascade is built at the top level by chaining tc to en.
REQ-031 SHALL stop elaboration with an error if MODULUS or RST_VAL is outside its range.

Verification
REQ-032 SHALL cover: WIDTH = 4, MODULUS = 10, up, en = 1 for 12 cycles from 0 -> count goes 0..9,0,1; tc high while count = 9; wrap high the cycle count = 0.
REQ-033 SHALL cover: down from count = 0 with en = 1 -> count = 9 and wrap pulses; on the next edge count = 8 and wrap = 0.
REQ-034 SHALL cover: load = 1 with data_in = 12 and en = 1 -> count = 9, load_err pulses once, wrap = 0.
REQ-035 SHALL cover: rst = 1 with load = 1 and data_in = 5 -> count = RST_VAL = 0; after rst drops with en = 1 and up -> count = 1.
REQ-036 SHALL cover: two instances, tens.en = units.tc, units counting up for 100 cycles -> pair reads 00..99,00, with tens stepping only when units wraps 9 -> 0.
REQ-037 SHALL cover: with COUNT_MOD_SAT_EN defined, up for 15 cycles from 0 -> count sticks at 9 and wrap never asserts.
